// File: rtl/instrument_frame_ctrl.sv
// Two-byte UART frame decoder for the instrument controller: assembles guitar/drum/bass
// fret lines, tracks framing errors and drops outputs when the link goes stale.
module instrument_frame_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 200000,
   parameter int unsigned STALE_CYCLES   = 5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic [4:0] guitar,
   output logic [4:0] drum,
   output logic [4:0] bass,
   output logic       frame_strobe,
   output logic       link_up,
   output logic [7:0] err_count
);

   localparam logic IDLE    = 1'b0;
   localparam logic WAIT_B2 = 1'b1;

   // Loaded with N-1 so that expiry lands on the N-th idle cycle after byte 1.
   localparam logic [23:0] TMO_LOAD  = 24'(TIMEOUT_CYCLES - 32'd1);
   localparam logic [23:0] STALE_MAX = 24'(STALE_CYCLES);

   function automatic logic [4:0] drum_decode(input logic [3:0] code);
      case (code)
         4'hF:    drum_decode = 5'b10001;
         4'hE:    drum_decode = 5'b10010;
         4'hD:    drum_decode = 5'b10100;
         4'hB:    drum_decode = 5'b11000;
         default: drum_decode = {1'b0, code};
      endcase
   endfunction

   logic        state_q, state_d;
   logic [6:0]  byte1_q, byte1_d;
   logic [23:0] tmo_q, tmo_d;
   logic [23:0] stale_q, stale_d;
   logic [4:0]  guitar_q, guitar_d;
   logic [4:0]  drum_q, drum_d;
   logic [4:0]  bass_q, bass_d;
   logic        strobe_q, strobe_d;
   logic        link_q, link_d;
   logic [7:0]  err_q, err_d;
   logic        commit_s;
   logic        err_s;
   logic        stale_hit_s;

   // Frame FSM, counters and output next-state logic.
   always_comb begin
      state_d  = state_q;
      byte1_d  = byte1_q;
      tmo_d    = tmo_q;
      commit_s = 1'b0;
      err_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_valid) begin
               if (rx_data[7]) begin
                  err_s = 1'b1;
               end else begin
                  byte1_d = rx_data[6:0];
                  tmo_d   = TMO_LOAD;
                  state_d = WAIT_B2;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_B2: begin
            if (rx_valid) begin
               if (rx_data[7]) begin
                  commit_s = 1'b1;
                  state_d  = IDLE;
               end else begin
                  err_s   = 1'b1;
                  byte1_d = rx_data[6:0];
                  tmo_d   = TMO_LOAD;
               end
            end else if (tmo_q == 24'd0) begin
               err_s   = 1'b1;
               byte1_d = 7'd0;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q - 24'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (commit_s) begin
         stale_d = 24'd0;
      end else if (stale_q != STALE_MAX) begin
         stale_d = stale_q + 24'd1;
      end else begin
         stale_d = stale_q;
      end
      stale_hit_s = !commit_s && (stale_d == STALE_MAX);

      // A commit in the stale-expiry cycle wins over the clear.
      if (commit_s) begin
         guitar_d = byte1_q[4:0];
         bass_d   = rx_data[6:2];
         drum_d   = drum_decode({rx_data[1:0], byte1_q[6:5]});
         link_d   = 1'b1;
      end else if (stale_hit_s) begin
         guitar_d = 5'd0;
         bass_d   = 5'd0;
         drum_d   = 5'd0;
         link_d   = 1'b0;
      end else begin
         guitar_d = guitar_q;
         bass_d   = bass_q;
         drum_d   = drum_q;
         link_d   = link_q;
      end

      if (err_s && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end else begin
         err_d = err_q;
      end
      strobe_d = commit_s;
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         byte1_q  <= 7'd0;
         tmo_q    <= 24'd0;
         stale_q  <= 24'd0;
         guitar_q <= 5'd0;
         drum_q   <= 5'd0;
         bass_q   <= 5'd0;
         strobe_q <= 1'b0;
         link_q   <= 1'b0;
         err_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         byte1_q  <= byte1_d;
         tmo_q    <= tmo_d;
         stale_q  <= stale_d;
         guitar_q <= guitar_d;
         drum_q   <= drum_d;
         bass_q   <= bass_d;
         strobe_q <= strobe_d;
         link_q   <= link_d;
         err_q    <= err_d;
      end
   end

   assign guitar       = guitar_q;
   assign drum         = drum_q;
   assign bass         = bass_q;
   assign frame_strobe = strobe_q;
   assign link_up      = link_q;
   assign err_count    = err_q;

endmodule

// File: doc/instrument_frame_ctrl.md
INSTRUMENT_FRAME_CTRL -- requirements
Module: instrument_frame_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 200000, max clk cycles allowed between byte 1 and byte 2 of a frame (1..2^24-1).
REQ-002 SHALL have parameter STALE_CYCLES, default 5000000, clk cycles without a good frame before outputs are cleared (1..2^24-1).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe, rx_data valid (from async_receiver RxD_data_ready).
REQ-006 SHALL have port rx_data  input  8  received UART byte.
REQ-007 SHALL have port guitar  output  5  guitar fret lines, registered.
REQ-008 SHALL have port drum  output  5  decoded drum lines, registered.
REQ-009 SHALL have port bass  output  5  bass fret lines, registered.
REQ-010 SHALL have port frame_strobe  output  1  one-cycle pulse after outputs update.
REQ-011 SHALL have port link_up  output  1  high while good frames arrive within STALE_CYCLES.
REQ-012 SHALL have port err_count  output  8  saturating framing-error count.

Function
REQ-013 SHALL treat byte 1 as {1'b0, drum_lo[1:0], guitar[4:0]} and byte 2 as {1'b1, bass[4:0], drum_hi[1:0]}; drum code = {drum_hi, drum_lo}.
REQ-014 SHALL implement states IDLE and WAIT_B2; reset state IDLE.
REQ-015 IDLE, rx_valid, rx_data[7]=0: SHALL store byte 1, load timeout counter, go WAIT_B2.
REQ-016 IDLE, rx_valid, rx_data[7]=1: SHALL discard byte, increment err_count, stay IDLE.
REQ-017 WAIT_B2, rx_valid, rx_data[7]=1: SHALL commit frame, go IDLE.
REQ-018 WAIT_B2, rx_valid, rx_data[7]=0: SHALL increment err_count, replace stored byte 1, reload timeout, stay WAIT_B2 (resync).
REQ-019 WAIT_B2, no rx_valid for TIMEOUT_CYCLES cycles after byte 1: SHALL increment err_count, drop byte 1, go IDLE; rx_valid in the expiry cycle takes priority over timeout.
REQ-020 Commit: guitar, bass, drum SHALL take new values on the edge sampling byte 2's rx_valid; frame_strobe SHALL be high exactly the next cycle (latency 1 cycle from byte 2 strobe to strobe).
REQ-021 Drum decode SHALL be: 4'hF->5'b10001, 4'hE->5'b10010, 4'hD->5'b10100, 4'hB->5'b11000, any other code c->{1'b0,c}.
REQ-022 Outputs SHALL hold last committed values between frames.
REQ-023 Stale counter SHALL clear on every commit and increment otherwise, saturating at STALE_CYCLES.
REQ-024 When stale counter reaches STALE_CYCLES, guitar, drum, bass SHALL clear to 0 and link_up SHALL drop, same edge; no frame_strobe.
REQ-025 link_up SHALL rise on the edge of the first commit after reset or stale.
REQ-026 err_count SHALL saturate at 8'hFF; it is cleared only by reset.
REQ-027 Simultaneous commit and stale expiry: commit SHALL win (outputs update, link_up high).

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, guitar/drum/bass 0, frame_strobe 0, link_up 0, err_count 0, all counters 0, stored byte 1 discarded.
REQ-029 Reset asserted while in WAIT_B2 SHALL abandon the partial frame; a byte 2 arriving after release SHALL count as an error (REQ-016).

Verification
REQ-030 Bytes 8'h45 then 8'hAB -> guitar 5'h05, bass 5'h0A, drum code 4'hE -> drum 5'b10010, frame_strobe one cycle, link_up 1, err_count 0.
REQ-031 Bytes 8'h1F then 8'h80 -> guitar 5'h1F, bass 0, drum code 4'h0 -> drum 5'b00000; then 8'h60, 8'h83 -> drum code 4'hF -> drum 5'b10001.
REQ-032 Bytes 8'h81 (lone byte 2) then 8'h22, 8'h33, 8'h84 -> err_count 2, committed guitar 5'h13, drum code 4'h1 -> drum 5'b00001.
REQ-033 TIMEOUT_CYCLES=8: byte 8'h01 then idle 8 cycles then 8'h85 -> err_count 2, outputs unchanged, no frame_strobe.
REQ-034 STALE_CYCLES=20: one good frame then idle 20 cycles -> guitar/drum/bass 0, link_up 0; next good frame -> link_up 1.
REQ-035 err_count driven to 255 via 300 lone byte-2s -> holds 8'hFF; rst_n pulse mid-WAIT_B2 -> all outputs 0, err_count 0.
